// File: rtl/mmu_pkg.sv
// Shared types and constants for the address-translation unit and its TLB.
package mmu_pkg;

  localparam int PAGE_OFFSET_W = 12;
  localparam int VPN_W         = 20;
  localparam int PPN_W         = 20;
  localparam int SATP_MODE_BIT = 31;
  localparam int WRITE_ARM_BIT = 31;

  typedef struct packed {
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
    logic             valid;
  } tlb_entry_t;

  function automatic tlb_entry_t make_entry(input logic [VPN_W-1:0] vpn,
                                            input logic [PPN_W-1:0] ppn,
                                            input logic             valid);
    tlb_entry_t e;
    e.vpn   = vpn;
    e.ppn   = ppn;
    e.valid = valid;
    return e;
  endfunction

endpackage

// File: rtl/mmu_tlb_cam.sv
// Fully associative TLB: entry storage, indexed write and parallel match
// where the lowest matching index wins.
module tlb_cam
  import mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [VPN_W-1:0] i_wr_vpn,
  input  logic [PPN_W-1:0] i_wr_ppn,
  input  logic             i_wr_valid,
  input  logic [VPN_W-1:0] i_lookup_vpn,
  output logic             o_hit,
  output logic [PPN_W-1:0] o_ppn
);

  tlb_entry_t               r_entries [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0]   w_match;
  logic [IDX_W-1:0]         w_sel;

  // Entry array; a write lands at the edge, so a same-cycle lookup sees old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        r_entries[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_entries[i_wr_idx] <= make_entry(i_wr_vpn, i_wr_ppn, i_wr_valid);
    end
  end

  // Parallel compare and priority select; scanning downward leaves the lowest match.
  always_comb begin
    w_match = '0;
    w_sel   = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      w_match[i] = r_entries[i].valid && (r_entries[i].vpn == i_lookup_vpn);
      w_sel      = w_match[i] ? IDX_W'(i) : w_sel;
    end
  end

  assign o_hit = |w_match;
  assign o_ppn = r_entries[w_sel].ppn;

endmodule

// File: rtl/mmu.sv
// Sv32-style translation unit: one-cycle lookup against a software-managed
// TLB, with bare-mode bypass and results held between lookups.
module mmu
  import mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_lookup,
  input  logic [31:0] virt_addr,
  output logic [31:0] phys_addr,
  output logic        lookup_done,
  output logic        tlb_hit,
  output logic        tlb_miss,
  input  logic [31:0] satp,
  input  logic [31:0] tlb_vpn_in,
  input  logic [31:0] tlb_ppn_perms_in,
  input  logic [31:0] tlb_write_index
);

  logic [31:0]      r_phys_addr;
  logic             r_lookup_done;
  logic             r_tlb_hit;
  logic             r_tlb_miss;
  logic [31:0]      r_prev_index;

  logic             w_wr_en;
  logic             w_cam_hit;
  logic [PPN_W-1:0] w_cam_ppn;
  logic [31:0]      w_next_pa;
  logic             w_next_hit;
  logic             w_next_miss;
  logic             w_unused;

  // A write fires only on a change of the index CSR with the arm bit set.
  assign w_wr_en = (tlb_write_index != r_prev_index) && tlb_write_index[WRITE_ARM_BIT];

  tlb_cam #(
    .TLB_ENTRIES(TLB_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_cam (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (tlb_write_index[IDX_W-1:0]),
    .i_wr_vpn    (tlb_vpn_in[VPN_W-1:0]),
    .i_wr_ppn    (tlb_ppn_perms_in[PPN_W+9:10]),
    .i_wr_valid  (tlb_ppn_perms_in[0]),
    .i_lookup_vpn(virt_addr[31:PAGE_OFFSET_W]),
    .o_hit       (w_cam_hit),
    .o_ppn       (w_cam_ppn)
  );

  // Lookup result for the current request: bypass, hit or miss.
  always_comb begin
    w_next_pa   = 32'h0000_0000;
    w_next_hit  = 1'b0;
    w_next_miss = 1'b0;
    if (!satp[SATP_MODE_BIT]) begin
      w_next_pa  = virt_addr;
      w_next_hit = 1'b1;
    end else if (w_cam_hit) begin
      w_next_pa  = {w_cam_ppn, virt_addr[PAGE_OFFSET_W-1:0]};
      w_next_hit = 1'b1;
    end else begin
      w_next_miss = 1'b1;
    end
  end

  // Output registers hold the last result until the next request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phys_addr   <= 32'h0000_0000;
      r_lookup_done <= 1'b0;
      r_tlb_hit     <= 1'b0;
      r_tlb_miss    <= 1'b0;
      r_prev_index  <= 32'h0000_0000;
    end else begin
      r_lookup_done <= start_lookup;
      r_prev_index  <= tlb_write_index;
      if (start_lookup) begin
        r_phys_addr <= w_next_pa;
        r_tlb_hit   <= w_next_hit;
        r_tlb_miss  <= w_next_miss;
      end
    end
  end

  assign phys_addr   = r_phys_addr;
  assign lookup_done = r_lookup_done;
  assign tlb_hit     = r_tlb_hit;
  assign tlb_miss    = r_tlb_miss;

  // Flag bits and high CSR bits are architecturally ignored here.
  assign w_unused = ^{satp[SATP_MODE_BIT-1:0], tlb_vpn_in[31:VPN_W],
                      tlb_ppn_perms_in[31:PPN_W+10], tlb_ppn_perms_in[9:1],
                      tlb_write_index[WRITE_ARM_BIT-1:IDX_W]};

endmodule

// File: tb/tb_mmu.sv
// Directed self-checking bench for the mmu translation unit.
module tb_mmu;

  logic        clk;
  logic        reset;
  logic        start_lookup;
  logic [31:0] virt_addr;
  logic [31:0] phys_addr;
  logic        lookup_done;
  logic        tlb_hit;
  logic        tlb_miss;
  logic [31:0] satp;
  logic [31:0] tlb_vpn_in;
  logic [31:0] tlb_ppn_perms_in;
  logic [31:0] tlb_write_index;

  int n_cmp;
  int n_err;

  mmu #(.TLB_ENTRIES(16), .IDX_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_lookup    (start_lookup),
    .virt_addr       (virt_addr),
    .phys_addr       (phys_addr),
    .lookup_done     (lookup_done),
    .tlb_hit         (tlb_hit),
    .tlb_miss        (tlb_miss),
    .satp            (satp),
    .tlb_vpn_in      (tlb_vpn_in),
    .tlb_ppn_perms_in(tlb_ppn_perms_in),
    .tlb_write_index (tlb_write_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] pa,
                           input logic done, input logic hit, input logic miss);
    check({tag, ".pa"},   phys_addr, pa);
    check({tag, ".done"}, {31'd0, lookup_done}, {31'd0, done});
    check({tag, ".hit"},  {31'd0, tlb_hit}, {31'd0, hit});
    check({tag, ".miss"}, {31'd0, tlb_miss}, {31'd0, miss});
  endtask

  // One lookup: request across one edge, then check at the following negedge.
  task automatic lookup(input string tag, input logic [31:0] va,
                        input logic [31:0] pa, input logic hit);
    start_lookup = 1'b1;
    virt_addr    = va;
    @(negedge clk);
    start_lookup = 1'b0;
    check_out(tag, pa, 1'b1, hit, ~hit);
  endtask

  task automatic tlb_write(input logic [3:0] idx, input logic [19:0] vpn,
                           input logic [19:0] ppn, input logic v);
    tlb_vpn_in       = {12'd0, vpn};
    tlb_ppn_perms_in = {2'b00, ppn, 9'd0, v};
    tlb_write_index  = {1'b1, 27'd0, idx};
    @(negedge clk);
  endtask

  initial begin
    n_cmp            = 0;
    n_err            = 0;
    reset            = 1'b1;
    start_lookup     = 1'b0;
    virt_addr        = 32'h0000_0000;
    satp             = 32'h0000_0000;
    tlb_vpn_in       = 32'h0000_0000;
    tlb_ppn_perms_in = 32'h0000_0000;
    tlb_write_index  = 32'h0000_0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_out("reset", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    // Bare mode passthrough, done pulses once, result held afterwards.
    lookup("bare", 32'h0000_1234, 32'h0000_1234, 1'b1);
    @(negedge clk);
    check_out("bare_hold", 32'h0000_1234, 1'b0, 1'b1, 1'b0);

    // Translate mode with an empty TLB.
    satp = 32'h8000_0000;
    lookup("miss_empty", 32'h0040_0010, 32'h0000_0000, 1'b0);

    // Fill entry 3 and hit it.
    tlb_write(4'd3, 20'h00400, 20'h80020, 1'b1);
    lookup("fill_hit", 32'h0040_0ABC, 32'h8002_0ABC, 1'b1);

    // Write and lookup in the same cycle: old contents first, new entry next.
    tlb_vpn_in       = 32'h0000_0600;
    tlb_ppn_perms_in = {2'b00, 20'h11111, 9'd0, 1'b1};
    tlb_write_index  = 32'h8000_0004;
    lookup("wr_same_cycle", 32'h0060_0123, 32'h0000_0000, 1'b0);
    lookup("wr_next", 32'h0060_0123, 32'h1111_1123, 1'b1);

    // Invalid entry never matches.
    tlb_write(4'd5, 20'h00500, 20'h22222, 1'b0);
    lookup("invalid", 32'h0050_0000, 32'h0000_0000, 1'b0);

    // Duplicate VPNs: lowest index wins.
    tlb_write(4'd7, 20'h12345, 20'hBBBBB, 1'b1);
    tlb_write(4'd2, 20'h12345, 20'hAAAAA, 1'b1);
    lookup("prio_low", 32'h1234_5678, 32'hAAAA_A678, 1'b1);

    // Back-to-back lookups keep done high.
    start_lookup = 1'b1;
    virt_addr    = 32'h0040_0001;
    @(negedge clk);
    check_out("b2b_first", 32'h8002_0001, 1'b1, 1'b1, 1'b0);
    lookup("b2b_second", 32'h0000_0000, 32'h0000_0000, 1'b0);

    // Holding the armed index again must not rewrite; disarm then rewrite entry 2 invalid.
    tlb_write_index = 32'h0000_0002;
    @(negedge clk);
    tlb_write(4'd2, 20'h12345, 20'hAAAAA, 1'b0);
    lookup("prio_rewrite", 32'h1234_5678, 32'hBBBB_B678, 1'b1);

    // Bare mode ignores the TLB; entries survive a mode toggle.
    satp = 32'h7FFF_FFFF;
    lookup("bare_again", 32'h1234_5678, 32'h1234_5678, 1'b1);
    satp = 32'h8000_0000;
    lookup("no_flush", 32'h0040_0FFF, 32'h8002_0FFF, 1'b1);

    // Reset while done is high clears everything immediately.
    tlb_write_index = 32'h0000_0000;
    lookup("pre_reset", 32'h0060_0456, 32'h1111_1456, 1'b1);
    reset = 1'b1;
    #1;
    check_out("reset_mid", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    lookup("post_reset_miss", 32'h0060_0456, 32'h0000_0000, 1'b0);
    @(negedge clk);
    check({"post_reset_done_low"}, {31'd0, lookup_done}, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
